// File: rtl/instr_seq_pkg.sv
// rtl/instr_seq_pkg.sv - shared types and constants for the instruction sequencer
package instr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_ERR
    } state_t;

    localparam logic [31:0] HALT_INSTR      = 32'hFFFF_FFFF;
    localparam logic [3:0]  IMM_ALU_OP      = 4'b0000;
    localparam int          TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decode of an instruction word into ALU controls
module instr_decode
    import instr_seq_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        imm_sel
);

    logic unused_bits;
    assign unused_bits = ^{ir[30:6], ir[4:3]};

    always_comb begin
        imm_sel = ir[31];
        if (ir[31]) begin
            alu_op  = IMM_ALU_OP;
            alu_src = 1'b1;
        end else begin
            alu_op  = {ir[5], ir[2:0]};
            alu_src = ~ir[5];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/exec/writeback sequencer with fetch timeout
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              alu_src,
    output logic [3:0]        alu_op,
    output logic              imm_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last wait count at which an ack is still accepted; no ack here means timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              alu_src_q, alu_src_d;
    logic              imm_sel_q, imm_sel_d;

    logic [3:0]        dec_alu_op;
    logic              dec_alu_src;
    logic              dec_imm_sel;

    instr_decode u_decode (
        .ir      (ir_q[31:0]),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .imm_sel (dec_imm_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            alu_op_q   <= '0;
            alu_src_q  <= 1'b0;
            imm_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            alu_op_q   <= alu_op_d;
            alu_src_q  <= alu_src_d;
            imm_sel_q  <= imm_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        wait_cnt_d = '0;
        alu_op_d   = alu_op_q;
        alu_src_d  = alu_src_q;
        imm_sel_d  = imm_sel_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (ir_q[31:0] == HALT_INSTR) begin
                    state_d = ST_IDLE;
                end else begin
                    alu_op_d  = dec_alu_op;
                    alu_src_d = dec_alu_src;
                    imm_sel_d = dec_imm_sel;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                pc_d    = pc_q + 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        imem_req  = (state_q == ST_FETCH);
        rf_we     = (state_q == ST_WB);
        busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                    (state_q == ST_EXEC)  || (state_q == ST_WB);
        err       = (state_q == ST_ERR);
        imem_addr = pc_q;
        pc        = pc_q;
        alu_op    = alu_op_q;
        alu_src   = alu_src_q;
        imm_sel   = imm_sel_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic        rf_we;
    logic [7:0]  pc;
    logic        busy;
    logic        err;

    logic        start2 = 1'b0;
    logic        imem_req2;
    logic [1:0]  imem_addr2;
    logic        imem_ack2 = 1'b0;
    logic [31:0] imem_rdata2 = 32'h0000_0001;
    logic        alu_src2;
    logic [3:0]  alu_op2;
    logic        imm_sel2;
    logic        rf_we2;
    logic [1:0]  pc2;
    logic        busy2;
    logic        err2;

    instr_sequencer #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .alu_src(alu_src), .alu_op(alu_op),
        .imm_sel(imm_sel), .rf_we(rf_we), .pc(pc), .busy(busy), .err(err)
    );

    instr_sequencer #(.ADDR_W(2), .DATA_W(32), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .alu_src(alu_src2), .alu_op(alu_op2),
        .imm_sel(imm_sel2), .rf_we(rf_we2), .pc(pc2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pc;
        logic [3:0] op;
        logic       src;
        logic       imm;
        int         lat;
    } exp_t;

    exp_t        wb_q[$];
    int          delay_q[$];
    logic [31:0] prog [0:255];
    int          dly_arr [0:15];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          in_fetch = 1'b0;
    int          wcnt = 0;
    int          cur_delay = 0;
    bit          mon_req_prev = 1'b0;
    int          mon_fstart = 0;
    logic [7:0]  mon_faddr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: the architectural result of one instruction and its latency.
    function automatic exp_t model(input int p, input logic [31:0] ins, input int d);
        exp_t e;
        e.pc  = p;
        e.lat = d + 4;
        e.imm = ins[31];
        if (ins[31]) begin
            e.op  = 4'd0;
            e.src = 1'b1;
        end else begin
            e.op  = {ins[5], ins[2:0]};
            e.src = !ins[5];
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: acks each fetch after a queued delay (255 = never); spurious acks otherwise.
    initial forever begin
        @(negedge clk);
        imem_ack = 1'b0;
        if (imem_req) begin
            if (!in_fetch) begin
                in_fetch  = 1'b1;
                wcnt      = 0;
                cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            end
            if (wcnt == cur_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = prog[imem_addr];
                in_fetch   = 1'b0;
            end else begin
                wcnt++;
            end
        end else begin
            in_fetch   = 1'b0;
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
        end
    end

    initial forever begin
        @(negedge clk);
        imem_ack2 = imem_req2;
    end

    // Monitor: address stability during fetch, and scoreboard pop on every rf_we.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            mon_req_prev = 1'b0;
        end else begin
            if (imem_req && !mon_req_prev) begin
                mon_fstart = cyc;
                mon_faddr  = imem_addr;
            end else if (imem_req) begin
                check("imem_addr_stable", imem_addr, mon_faddr);
            end
            mon_req_prev = imem_req;
            if (rf_we) begin
                if (wb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rf_we: got rf_we at pc=%0d, expected none", pc);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_pc", pc, e.pc);
                    check("wb_alu_op", alu_op, e.op);
                    check("wb_alu_src", alu_src, e.src);
                    check("wb_imm_sel", imm_sel, e.imm);
                    check("wb_latency", cyc - mon_fstart + 1, e.lat);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_in_time"}, busy, 0);
    endtask

    task automatic run_prog(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            wb_q.push_back(model(i, prog[i], dly_arr[i]));
            delay_q.push_back(dly_arr[i]);
        end
        prog[n] = 32'hFFFF_FFFF;
        delay_q.push_back(dly_arr[n]);
        pulse_start();
        wait_idle(tag, 30 * (n + 1));
        check({tag, "_pc"}, pc, n);
        check({tag, "_err"}, err, 0);
        check({tag, "_wb_drained"}, wb_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_req"}, imem_req, 0);
        check({tag, "_rf_we"}, rf_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_alu_src"}, alu_src, 0);
        check({tag, "_imm_sel"}, imm_sel, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        for (int i = 0; i < 256; i++) prog[i] = '0;

        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_after_reset_busy", busy, 0);

        prog[0] = 32'h0000_0022; dly_arr[0] = 0; dly_arr[1] = 0;
        run_prog("reg_op", 1);
        prog[0] = 32'h8000_0005; dly_arr[0] = 3; dly_arr[1] = 0;
        run_prog("imm_op", 1);
        prog[0] = 32'h0000_0003; dly_arr[0] = 14; dly_arr[1] = 2;
        run_prog("ack_at_expiry", 1);
        prog[0] = 32'h0000_0001; dly_arr[0] = 0; dly_arr[1] = 0;
        run_prog("halt_prog", 1);

        // Timeout on the second fetch, then recover from ERR.
        prog[0] = 32'h0000_0001;
        wb_q.push_back(model(0, prog[0], 0));
        delay_q.push_back(0);
        delay_q.push_back(255);
        pulse_start();
        k = 0;
        while (!err && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("timeout_err", err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_imem_req", imem_req, 0);
        check("timeout_pc", pc, 1);
        check("timeout_fetch_cycles", cyc - mon_fstart, 15);
        prog[0] = 32'hFFFF_FFFF;
        delay_q.push_back(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("recover_imem_req", imem_req, 1);
        check("recover_addr", imem_addr, 0);
        check("recover_err", err, 0);
        check("recover_busy", busy, 1);
        wait_idle("recover", 40);
        check("recover_pc", pc, 0);

        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i <= n; i++) begin
                prog[i] = $urandom;
                if (prog[i] == 32'hFFFF_FFFF) prog[i] = 32'h7FFF_FFFF;
                dly_arr[i] = $urandom_range(0, 14);
            end
            run_prog("random", n);
        end

        // Reset while the fetch at pc=1 is waiting.
        prog[0] = 32'h0000_0001; prog[1] = 32'h0000_0001;
        wb_q.push_back(model(0, prog[0], 0));
        delay_q.push_back(0);
        delay_q.push_back(255);
        pulse_start();
        k = 0;
        while (!(imem_req && imem_addr == 8'd1) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("midfetch_reached", imem_addr, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_midfetch");
        delay_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midfetch_idle_busy", busy, 0);
        check("midfetch_idle_req", imem_req, 0);
        check("midfetch_wb_drained", wb_q.size(), 0);

        // Reset during the writeback cycle.
        prog[0] = 32'h8000_0000; prog[1] = 32'hFFFF_FFFF;
        wb_q.push_back(model(0, prog[0], 0));
        delay_q.push_back(0);
        delay_q.push_back(0);
        pulse_start();
        k = 0;
        while (!rf_we && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("midwb_reached", rf_we, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_midwb");
        delay_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midwb_idle_busy", busy, 0);
        check("midwb_idle_pc", pc, 0);
        check("midwb_wb_drained", wb_q.size(), 0);

        // Narrow-pc instance: four instructions wrap pc from 3 back to 0.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 0;
        k = 0;
        while (seen < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (rf_we2) begin
                seen++;
                if (seen == 4) check("wrap_pc_before", pc2, 3);
            end
        end
        check("wrap_wb_count", seen, 4);
        @(negedge clk);
        check("wrap_pc_after", pc2, 0);
        check("wrap_addr_after", imem_addr2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 8, instruction memory word-address width
- DATA_W, 32, instruction width
- TIMEOUT, 15, maximum cycles the block waits for imem_ack
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous, active-high reset
- start, in, 1, begin execution from pc=0 when idle
- imem_req, out, 1, fetch request, held until ack
- imem_addr, out, ADDR_W, fetch word address (equals pc)
- imem_ack, in, 1, fetch data valid this cycle
- imem_rdata, in, DATA_W, fetched instruction
- alu_src, out, 1, 1 = ALU operand B from immediate
- alu_op, out, 4, ALU operation select
- imm_sel, out, 1, immediate-format instruction
- rf_we, out, 1, register-file write strobe, one cycle
- pc, out, ADDR_W, current program counter
- busy, out, 1, sequencer not in IDLE or ERR
- err, out, 1, fetch timeout occurred

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB, ERR.
REQ-004 IDLE: on start=1, the block SHALL clear pc to 0 and go to FETCH next cycle; otherwise it SHALL stay in IDLE.
REQ-005 FETCH: imem_req SHALL be 1 and imem_addr SHALL equal pc and remain stable until the ack cycle; on imem_ack=1, the block SHALL capture imem_rdata into the instruction register and go to DECODE.
REQ-006 FETCH SHALL count wait cycles from 0. If the count reaches TIMEOUT without an ack, the block SHALL go to ERR. If ack arrives in the same cycle as expiry, ack SHALL win.
REQ-007 DECODE, for captured instruction ir:
- If ir is all-ones (HALT), the block SHALL return to IDLE with pc unchanged.
- Otherwise it SHALL latch the control fields and go to EXEC.
REQ-008 Decode rules:
- imm_sel = ir[31].
- If ir[31]=1: alu_op=4'b0000 and alu_src=1.
- Else: alu_op={ir[5],ir[2:0]} and alu_src=~ir[5].
REQ-009 alu_op, alu_src and imm_sel SHALL be registered, change only on DECODE exit, and hold through EXEC and WB.
REQ-010 EXEC SHALL last exactly one cycle, then go to WB.
REQ-011 WB SHALL assert rf_we for exactly that cycle, set pc to pc+1 (modulo 2^ADDR_W, wrapping to 0), and go to FETCH.
REQ-012 Latency: each non-HALT instruction SHALL take 4 cycles plus the imem wait cycles (ack in the first FETCH cycle gives 4 cycles).
REQ-013 start SHALL be ignored outside IDLE and ERR.
REQ-014 imem_ack SHALL be ignored outside FETCH.
REQ-015 ERR: err=1 and busy=0; on start=1, the block SHALL clear err and pc and go to FETCH.
REQ-016 busy SHALL be 1 exactly in FETCH, DECODE, EXEC and WB.

Reset
REQ-017 On rst=1, asynchronously: state=IDLE, pc=0, instruction register=0, wait count=0, and imem_req, rf_we, alu_src, alu_op, imm_sel, busy and err all 0.
REQ-018 Reset mid-fetch SHALL drop imem_req in the same cycle. No rf_we SHALL be issued for an interrupted instruction.
REQ-019 After rst deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-020 Package instr_seq_pkg SHALL hold the state enum, the HALT encoding (all-ones), the immediate default alu_op 4'b0000, and the TIMEOUT default.
REQ-021 A combinational sub-module instr_decode SHALL implement REQ-008. The FSM, counters and registers SHALL live in instr_sequencer.

Verification
REQ-022 Fetch 32'h0000_0022 with immediate ack -> alu_op=4'b1010, alu_src=0, imm_sel=0; rf_we pulses in the 4th cycle after the FETCH entry; pc goes 0->1.
REQ-023 Fetch 32'h8000_0005 with ack after 3 wait cycles -> alu_op=4'b0000, alu_src=1, imm_sel=1; 7 cycles FETCH-to-WB-exit.
REQ-024 No ack for 15 cycles -> ERR, err=1, busy=0, imem_req=0; then start=1 -> FETCH at pc=0 with err=0.
REQ-025 Ack asserted in the 15th wait cycle -> DECODE, not ERR.
REQ-026 Program {32'h0000_0001, 32'hFFFF_FFFF} -> one rf_we pulse, then IDLE with pc=1. Separately, with ADDR_W=2, run 4 non-HALT instructions -> pc wraps 3->0.
REQ-027 rst asserted mid-FETCH and mid-WB -> all outputs 0 immediately, no further rf_we, and IDLE held until start.
